// File: rtl/fast_serial_pkg.sv
// Shared constants and helpers for the fast-serial receive/transmit blocks.
// Drop counter width is used only when FSRX_FIFO_DROP_CNT_EN is defined.
package fast_serial_pkg;

    localparam int FS_BYTE_W     = 8;
    localparam int FS_DROP_CNT_W = 16;

    function automatic int fs_level_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/fastserial_fifo_ram.sv
// Byte-wide register array: synchronous write port, asynchronous read port.
module fastserial_fifo_ram
    import fast_serial_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [FS_BYTE_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]    i_raddr,
    output logic [FS_BYTE_W-1:0] o_rdata
);

    logic [FS_BYTE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/fastserial_rx_fifo.sv
// FWFT byte FIFO from rx_fastserial to the Avalon-ST byte sink.
// Define FSRX_FIFO_DROP_CNT_EN to add the saturating o_drop_count output.
module fastserial_rx_fifo
    import fast_serial_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [FS_BYTE_W-1:0]     i_data,
    input  logic                     i_ready,
    output logic [FS_BYTE_W-1:0]     o_st_data,
    output logic                     o_st_valid,
    input  logic                     i_st_ready,
    output logic [DEPTH_LOG2:0]      o_level,
    output logic                     o_almost_full,
    output logic                     o_overflow,
`ifdef FSRX_FIFO_DROP_CNT_EN
    output logic [FS_DROP_CNT_W-1:0] o_drop_count,
`endif
    input  logic                     i_clear_overflow
);

    localparam int LW = fs_level_w(DEPTH_LOG2);
    localparam logic [LW-1:0] DEPTH_L  = LW'(2**DEPTH_LOG2);
    localparam logic [LW-1:0] MARGIN_L = LW'(AFULL_MARGIN);

    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [LW-1:0]         level_next;
    logic [LW-1:0]         free_next;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign full       = (o_level == DEPTH_L);
    assign o_st_valid = (o_level != '0);
    assign pop        = o_st_valid && i_st_ready;
    // A pop in the same cycle frees a slot, so a strobe while full still lands.
    assign push       = i_ready && (!full || pop);
    assign drop       = i_ready && full && !pop;

    always_comb begin
        level_next = o_level;
        unique case ({push, pop})
            2'b10:   level_next = o_level + LW'(1);
            2'b01:   level_next = o_level - LW'(1);
            default: level_next = o_level;
        endcase
    end

    assign free_next = DEPTH_L - level_next;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            o_level       <= '0;
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_level       <= level_next;
            o_almost_full <= (free_next <= MARGIN_L);
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                o_overflow <= 1'b0;
            end
        end
    end

`ifdef FSRX_FIFO_DROP_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_drop_count <= '0;
        end else if (i_clear_overflow) begin
            o_drop_count <= drop ? FS_DROP_CNT_W'(1) : '0;
        end else if (drop && (o_drop_count != '1)) begin
            o_drop_count <= o_drop_count + 1'b1;
        end
    end
`endif

    fastserial_fifo_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (push && i_reset_n),
        .i_waddr (wr_ptr),
        .i_wdata (i_data),
        .i_raddr (rd_ptr),
        .o_rdata (o_st_data)
    );

endmodule

// File: tb/tb_fastserial_rx_fifo.sv
// Directed scoreboard bench for fastserial_rx_fifo.
// Drop counter checks run when FSRX_FIFO_DROP_CNT_EN is defined.
module tb_fastserial_rx_fifo;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_ready = 1'b0;
    logic [7:0]  o_st_data;
    logic        o_st_valid;
    logic        i_st_ready = 1'b0;
    logic [4:0]  o_level;
    logic        o_almost_full;
    logic        o_overflow;
    logic        i_clear_overflow = 1'b0;
`ifdef FSRX_FIFO_DROP_CNT_EN
    logic [15:0] o_drop_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] sb [$];

    always #5 i_clk = ~i_clk;

    fastserial_rx_fifo #(
        .DEPTH_LOG2   (4),
        .AFULL_MARGIN (2)
    ) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_data           (i_data),
        .i_ready          (i_ready),
        .o_st_data        (o_st_data),
        .o_st_valid       (o_st_valid),
        .i_st_ready       (i_st_ready),
        .o_level          (o_level),
        .o_almost_full    (o_almost_full),
        .o_overflow       (o_overflow),
`ifdef FSRX_FIFO_DROP_CNT_EN
        .o_drop_count     (o_drop_count),
`endif
        .i_clear_overflow (i_clear_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One cycle of stimulus; any pop this cycle is checked against the queue.
    task automatic step(input logic strb, input logic [7:0] d,
                        input logic srdy, input logic clr,
                        input logic exp_push);
        i_ready          = strb;
        i_data           = d;
        i_st_ready       = srdy;
        i_clear_overflow = clr;
        if (o_st_valid && srdy) begin
            if (sb.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("st_data", {24'h0, o_st_data}, {24'h0, sb.pop_front()});
        end
        if (strb && exp_push) sb.push_back(d);
        tick();
        i_ready          = 1'b0;
        i_clear_overflow = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 40;
        while (sb.size() > 0 && budget > 0) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            budget--;
        end
        chk("drain_budget", sb.size(), 0);
    endtask

    initial begin
        tick();
        tick();
        i_reset_n = 1'b1;
        chk("rst_valid", o_st_valid, 0);
        chk("rst_level", o_level, 0);
        chk("rst_afull", o_almost_full, 0);
        chk("rst_ovf", o_overflow, 0);

        // single byte, FWFT latency of one cycle
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        chk("a5_valid", o_st_valid, 1);
        chk("a5_level", o_level, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("a5_level0", o_level, 0);
        chk("a5_valid0", o_st_valid, 0);

        // fill to full with sink stalled
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
            chk("fill_level", o_level, i + 1);
            chk("fill_afull", o_almost_full, (i + 1 >= 14) ? 1 : 0);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            chk("fill_hold", o_st_data, 8'h00);
        end
        chk("full_ovf", o_overflow, 0);

        // drop while full
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("drop_ovf", o_overflow, 1);
        chk("drop_level", o_level, 16);

        // push coincident with pop while full
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        chk("pp_level", o_level, 16);
        chk("pp_ovf", o_overflow, 1);
        drain();
        chk("drained_level", o_level, 0);
        chk("drained_afull", o_almost_full, 0);
        chk("drained_valid", o_st_valid, 0);

        // mid-stream reset with a strobe in the reset cycle
        for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        chk("pre_rst_level", o_level, 5);
        chk("pre_rst_ovf", o_overflow, 1);
        i_reset_n = 1'b0;
        i_ready   = 1'b1;
        i_data    = 8'h77;
        tick();
        i_reset_n = 1'b1;
        i_ready   = 1'b0;
        sb.delete();
        chk("mrst_valid", o_st_valid, 0);
        chk("mrst_level", o_level, 0);
        chk("mrst_ovf", o_overflow, 0);
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("post_rst_level", o_level, 0);

        // overflow set/clear priority
        for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
        chk("ovf3", o_overflow, 1);
`ifdef FSRX_FIFO_DROP_CNT_EN
        chk("drop_cnt3", o_drop_count, 3);
`endif
        step(1'b1, 8'hDD, 1'b0, 1'b1, 1'b0);
        chk("ovf_set_wins", o_overflow, 1);
`ifdef FSRX_FIFO_DROP_CNT_EN
        chk("drop_cnt_clr1", o_drop_count, 1);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("ovf_clear", o_overflow, 0);
`ifdef FSRX_FIFO_DROP_CNT_EN
        chk("drop_cnt_clr0", o_drop_count, 0);
`endif
        chk("level_after_drops", o_level, 16);
        drain();
        chk("final_level", o_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
